// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the stage-0 fetch sequencer.
//   - default widths for code address, instruction word and age counter
//   - FSM state encoding
package fetch_sequencer_pkg;

   localparam int unsigned DEF_CODE_ADDR_WIDTH = 10;
   localparam int unsigned DEF_INSTR_WIDTH     = 64;
   localparam int unsigned DEF_COUNT_WIDTH     = 6;

   typedef enum logic [0:0] {
      FS_IDLE  = 1'b0,
      FS_FETCH = 1'b1
   } fs_state_e;

endpackage

// File: rtl/fetch_sequencer_skid_fifo.sv
// Two-entry fall-through FIFO carrying {instr, pc, age} between the code
// memory return path and the next pipeline stage.
//   clk, rst          clock, synchronous active-high reset
//   flush_i           drop all stored entries and the incoming push
//   push_i            return data valid this cycle
//   push_instr_i/pc_i returned instruction and its PC
//   pop_i             head consumed this cycle (only meaningful with vld_o)
//   vld_o, head_*_o   head entry; an empty FIFO forwards the push directly
//   count_o           number of stored entries (0..2)
module fetch_sequencer_skid_fifo #(
   parameter int DW = 64,
   parameter int AW = 10,
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [DW-1:0] push_instr_i,
   input  logic [AW-1:0] push_pc_i,
   input  logic          pop_i,
   output logic          vld_o,
   output logic [DW-1:0] head_instr_o,
   output logic [AW-1:0] head_pc_o,
   output logic [CW-1:0] head_age_o,
   output logic [1:0]    count_o
);

   localparam logic [CW-1:0] AGE_MAX = '1;
   localparam logic [CW-1:0] AGE_ONE = CW'(1);

   function automatic logic [CW-1:0] age_inc(input logic [CW-1:0] a);
      return (a == AGE_MAX) ? a : a + 1'b1;
   endfunction

   logic [DW-1:0] instr_q [2];
   logic [DW-1:0] instr_d [2];
   logic [AW-1:0] pc_q    [2];
   logic [AW-1:0] pc_d    [2];
   logic [CW-1:0] age_q   [2];
   logic [CW-1:0] age_d   [2];
   logic [1:0]    count_q, count_d;

   // An entry that gets stored has already been shown for one cycle, so it
   // is written with the age it will carry on the next cycle.
   always_comb begin
      vld_o        = 1'b0;
      head_instr_o = '0;
      head_pc_o    = '0;
      head_age_o   = '0;
      if (count_q != 2'd0) begin
         vld_o        = 1'b1;
         head_instr_o = instr_q[0];
         head_pc_o    = pc_q[0];
         head_age_o   = age_q[0];
      end else if (push_i) begin
         vld_o        = 1'b1;
         head_instr_o = push_instr_i;
         head_pc_o    = push_pc_i;
         head_age_o   = AGE_ONE;
      end
   end

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      age_d   = age_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case (count_q)
            2'd0: begin
               if (push_i && !pop_i) begin
                  instr_d[0] = push_instr_i;
                  pc_d[0]    = push_pc_i;
                  age_d[0]   = age_inc(AGE_ONE);
                  count_d    = 2'd1;
               end
            end
            2'd1: begin
               if (pop_i && push_i) begin
                  instr_d[0] = push_instr_i;
                  pc_d[0]    = push_pc_i;
                  age_d[0]   = age_inc(AGE_ONE);
               end else if (pop_i) begin
                  count_d = 2'd0;
               end else if (push_i) begin
                  age_d[0]   = age_inc(age_q[0]);
                  instr_d[1] = push_instr_i;
                  pc_d[1]    = push_pc_i;
                  age_d[1]   = age_inc(AGE_ONE);
                  count_d    = 2'd2;
               end else begin
                  age_d[0] = age_inc(age_q[0]);
               end
            end
            2'd2: begin
               // A push cannot arrive while full: the issue credit forbids it.
               if (pop_i) begin
                  instr_d[0] = instr_q[1];
                  pc_d[0]    = pc_q[1];
                  age_d[0]   = age_inc(age_q[1]);
                  count_d    = 2'd1;
               end else begin
                  age_d[0] = age_inc(age_q[0]);
                  age_d[1] = age_inc(age_q[1]);
               end
            end
            default: count_d = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
            age_q[i]   <= '0;
         end
      end else begin
         count_q <= count_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         age_q   <= age_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Stage-0 fetch controller: owns the PC, issues reads to the synchronous
// code memory (1-cycle latency) and hands instructions to the next stage
// over vld/rdy. Handles start, halt and branch-mispredict redirect.
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin fetching at PC 0 (IDLE only)
//   halt                      flush and return to IDLE (wins over mispredict)
//   branch_mispredict/target  flush and redirect PC
//   code_addr/rd_en/rdata     code memory read port
//   instr_out/pc, ocount, vld head instruction, its PC and age
//   next_rdy                  next stage accepts the head
//   PC_en                     a read is issued and the PC advances
//   busy                      FSM is in FETCH
//
// state    | meaning
// FS_IDLE  | no reads issued; waiting for start
// FS_FETCH | issuing reads whenever a buffer credit is free
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int CODE_ADDR_WIDTH = DEF_CODE_ADDR_WIDTH,
   parameter int INSTR_WIDTH     = DEF_INSTR_WIDTH,
   parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       halt,
   input  logic                       branch_mispredict,
   input  logic [CODE_ADDR_WIDTH-1:0] branch_target,
   output logic [CODE_ADDR_WIDTH-1:0] code_addr,
   output logic                       code_rd_en,
   input  logic [INSTR_WIDTH-1:0]     code_rdata,
   output logic [INSTR_WIDTH-1:0]     instr_out,
   output logic [CODE_ADDR_WIDTH-1:0] instr_pc,
   output logic [COUNT_WIDTH-1:0]     ocount,
   output logic                       vld,
   input  logic                       next_rdy,
   output logic                       PC_en,
   output logic                       busy
);

   fs_state_e                  state_q, state_d;
   logic [CODE_ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CODE_ADDR_WIDTH-1:0] rd_pc_q;
   logic                       inflight_q;
   logic                       flush;
   logic                       push;
   logic                       pop;
   logic                       credit_ok;
   logic [1:0]                 fifo_count;

   // Stored entries plus the read in flight may never exceed the two slots.
   assign credit_ok = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && !inflight_q);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      flush      = 1'b0;
      code_rd_en = 1'b0;
      case (state_q)
         FS_IDLE: begin
            if (start) begin
               state_d = FS_FETCH;
               pc_d    = '0;
            end
         end
         FS_FETCH: begin
            code_rd_en = credit_ok && !halt && !branch_mispredict;
            if (halt) begin
               flush   = 1'b1;
               state_d = FS_IDLE;
            end else if (branch_mispredict) begin
               flush = 1'b1;
               pc_d  = branch_target;
            end else if (code_rd_en) begin
               pc_d = pc_q + 1'b1;
            end
         end
         default: state_d = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FS_IDLE;
         pc_q       <= '0;
         rd_pc_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         rd_pc_q    <= pc_q;
         inflight_q <= code_rd_en;
      end
   end

   // Data returning during a flush belongs to the abandoned path.
   assign push = inflight_q && !flush;
   assign pop  = vld && next_rdy;

   fetch_sequencer_skid_fifo #(
      .DW (INSTR_WIDTH),
      .AW (CODE_ADDR_WIDTH),
      .CW (COUNT_WIDTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .push_i       (push),
      .push_instr_i (code_rdata),
      .push_pc_i    (rd_pc_q),
      .pop_i        (pop),
      .vld_o        (vld),
      .head_instr_o (instr_out),
      .head_pc_o    (instr_pc),
      .head_age_o   (ocount),
      .count_o      (fifo_count)
   );

   assign code_addr = pc_q;
   assign PC_en     = code_rd_en;
   assign busy      = (state_q == FS_FETCH);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   localparam int AW   = 10;
   localparam int DW   = 64;
   localparam int CW   = 6;
   localparam int AMAX = 63;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          halt = 1'b0;
   logic          branch_mispredict = 1'b0;
   logic [AW-1:0] branch_target = '0;
   logic [AW-1:0] code_addr;
   logic          code_rd_en;
   logic [DW-1:0] code_rdata = '0;
   logic [DW-1:0] instr_out;
   logic [AW-1:0] instr_pc;
   logic [CW-1:0] ocount;
   logic          vld;
   logic          next_rdy = 1'b0;
   logic          PC_en;
   logic          busy;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .CODE_ADDR_WIDTH (AW),
      .INSTR_WIDTH     (DW),
      .COUNT_WIDTH     (CW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .halt              (halt),
      .branch_mispredict (branch_mispredict),
      .branch_target     (branch_target),
      .code_addr         (code_addr),
      .code_rd_en        (code_rd_en),
      .code_rdata        (code_rdata),
      .instr_out         (instr_out),
      .instr_pc          (instr_pc),
      .ocount            (ocount),
      .vld               (vld),
      .next_rdy          (next_rdy),
      .PC_en             (PC_en),
      .busy              (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: a list of instructions that exist downstream of the
   // memory (buffered ones with their age), plus at most one read in flight.
   typedef struct {
      int pc;
      int age;
   } ent_t;

   ent_t m_buf[$];
   bit   m_running  = 0;
   int   m_pc       = 0;
   bit   m_infl     = 0;
   int   m_infl_pc  = 0;
   bit   last_en    = 0;
   logic [AW-1:0] last_addr = '0;

   function automatic logic [DW-1:0] mem_word(input int a);
      return 64'h1000 + 64'(a);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input bit st, input bit hl, input bit bm, input int tgt,
                       input bit rdy, input bit r, input bit zchk);
      ent_t vis[$];
      bit   flush;
      bit   exp_en;
      bit   exp_vld;
      @(posedge clk);
      #1;
      code_rdata        = last_en ? mem_word(int'(last_addr)) : {$urandom, $urandom};
      rst               = r;
      start             = st;
      halt              = hl;
      branch_mispredict = bm;
      branch_target     = AW'(tgt);
      next_rdy          = rdy;
      #4;
      last_en   = code_rd_en;
      last_addr = code_addr;
      if (r) begin
         m_buf.delete();
         m_running = 0;
         m_pc      = 0;
         m_infl    = 0;
      end else begin
         flush  = m_running && (hl || bm);
         exp_en = m_running && ((m_buf.size() + int'(m_infl)) < 2) && !hl && !bm;
         vis    = m_buf;
         if (m_infl && !flush) vis.push_back('{m_infl_pc, 1});
         exp_vld = (vis.size() > 0);
         check("busy",       64'(busy),       64'(m_running));
         check("code_rd_en", 64'(code_rd_en), 64'(exp_en));
         check("PC_en",      64'(PC_en),      64'(exp_en));
         check("code_addr",  64'(code_addr),  64'(m_pc));
         check("vld",        64'(vld),        64'(exp_vld));
         if (exp_vld) begin
            check("instr_out", instr_out,     mem_word(vis[0].pc));
            check("instr_pc",  64'(instr_pc), 64'(vis[0].pc));
            check("ocount",    64'(ocount),   64'(vis[0].age));
         end
         if (zchk) begin
            check("rst_instr_out", instr_out,     64'(0));
            check("rst_instr_pc",  64'(instr_pc), 64'(0));
            check("rst_ocount",    64'(ocount),   64'(0));
         end
         // advance the model across the clock edge
         if (exp_vld && rdy) void'(vis.pop_front());
         if (flush) vis.delete();
         foreach (vis[i]) if (vis[i].age < AMAX) vis[i].age++;
         m_buf     = vis;
         m_infl    = exp_en;
         m_infl_pc = m_pc;
         if (exp_en) m_pc = (m_pc + 1) % (1 << AW);
         if (!m_running) begin
            if (st) begin
               m_running = 1;
               m_pc      = 0;
            end
         end else if (hl) begin
            m_running = 0;
         end else if (bm) begin
            m_pc = tgt;
         end
      end
   endtask

   initial begin
      // reset, then check reset values
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0, 1);
      // halt / mispredict ignored in IDLE
      step(0, 1, 0, 0, 1, 0, 0);
      step(0, 0, 1, 5, 1, 0, 0);
      // start and stream
      step(1, 0, 0, 0, 1, 0, 0);
      repeat (8) step(0, 0, 0, 0, 1, 0, 0);
      // backpressure then release; start ignored in FETCH
      repeat (5) step(0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0);
      repeat (6) step(0, 0, 0, 0, 1, 0, 0);
      // one entry buffered plus one read in flight, then mispredict
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0, 1, 0, 0);
      // halt and mispredict together, then idle
      step(0, 1, 1, 100, 1, 0, 0);
      repeat (4) step(0, 0, 0, 0, 1, 0, 0);
      // PC wrap across the top of the address space
      step(1, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 1, (1 << AW) - 4, 1, 0, 0);
      repeat (10) step(0, 0, 0, 0, 1, 0, 0);
      // age saturation
      repeat (70) step(0, 0, 0, 0, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0, 1, 0, 0);
      // reset with a read in flight, then restart
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0, 1);
      step(1, 0, 0, 0, 1, 0, 0);
      repeat (6) step(0, 0, 0, 0, 1, 0, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 19) == 0,
              $urandom_range(0, 39) == 0,
              $urandom_range(0, 24) == 0,
              int'($urandom_range(0, (1 << AW) - 1)),
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 499) == 0,
              0);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Stage-0 controller for the BPF CPU pipeline: owns the PC, issues reads to the synchronous code memory and presents fetched instructions to the next stage (stage0_point_5) over a vld/rdy handshake.
- Handles start, halt and branch-mispredict redirect, including flush of in-flight reads.
- Tracks per-instruction pipeline age for the downstream count chain.
- Sits between code memory and stage0_point_5 inside the bpfcpu.

Parameters:
- CODE_ADDR_WIDTH, 10, code memory address width (PC width).
- INSTR_WIDTH, 64, instruction word width.
- COUNT_WIDTH, 6, age counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin execution at PC 0.
- halt  in  1  pulse from a later stage (RET retired): stop fetching and flush.
- branch_mispredict  in  1  pulse: flush and redirect.
- branch_target  in  CODE_ADDR_WIDTH  redirect PC, valid with branch_mispredict.
- code_addr  out  CODE_ADDR_WIDTH  code memory read address.
- code_rd_en  out  1  code memory read enable; data returns exactly 1 cycle later.
- code_rdata  in  INSTR_WIDTH  code memory read data.
- instr_out  out  INSTR_WIDTH  instruction to the next stage.
- instr_pc  out  CODE_ADDR_WIDTH  PC of instr_out.
- ocount  out  COUNT_WIDTH  cycles since the instruction was issued.
- vld  out  1  instr_out valid.
- next_rdy  in  1  next stage ready.
- PC_en  out  1  high in the cycle the PC advances (read issued).
- busy  out  1  high in FETCH.

Behaviour:
- Reset values: state=IDLE, PC=0, code_rd_en=0, code_addr=0, vld=0, instr_out=0, instr_pc=0, ocount=0, PC_en=0, busy=0. Buffer and in-flight flag are cleared.
- States:
  - IDLE: no reads. start -> FETCH with PC=0. halt and branch_mispredict are ignored.
  - FETCH: start is ignored. halt -> IDLE. branch_mispredict stays in FETCH with a redirect.
- Issue rule (FETCH): code_rd_en = (occupancy + inflight < 2) && !halt && !branch_mispredict.
  - code_addr = PC.
  - PC_en = code_rd_en.
  - On issue, PC <= PC+1, wrapping modulo 2^CODE_ADDR_WIDTH.
  - Throughput is 1 instruction/cycle when next_rdy is held high.
- Return path: one cycle after issue, code_rdata is written into a 2-entry FIFO with its PC. Its age starts at 1.
- Output: vld = FIFO non-empty. instr_out, instr_pc and ocount come from the head entry. Pop when vld && next_rdy.
  - vld and head data must stay stable while next_rdy=0.
  - Zero-bubble path: an issue at cycle t gives vld at cycle t+1 when the FIFO is empty.
- Age: each buffered entry's age increments every cycle and saturates at 2^COUNT_WIDTH-1.
- branch_mispredict (FETCH), same cycle: FIFO cleared, in-flight read marked dead (its data is discarded next cycle), PC <= branch_target. No issue this cycle; the first issue at branch_target happens on the next cycle. vld=0 the cycle after the pulse.
- halt (FETCH): same flush as mispredict, then state <= IDLE and PC unchanged. halt and branch_mispredict together: halt wins.
- Simultaneous pop and return-write on a full FIFO cannot occur, because of the credit rule. Simultaneous push and pop on a 1-entry FIFO keeps occupancy at 1.
- rst mid-operation: all state is reset in one cycle and any returning read is discarded.

Decomposition:
- Shared bpf_defs.vh holds the state encodings (FS_IDLE, FS_FETCH) and the default widths CODE_ADDR_WIDTH and INSTR_WIDTH.
- Sub-module fetch_skid_fifo is natural: a 2-entry FIFO carrying {instr, pc, age} with push, pop, flush and saturating age increment.
- The FSM, PC and credit logic live in the top.

Test Plan:
- Reset, then start with next_rdy=1 and memory word = 0x1000+addr -> code_addr 0,1,2,... each cycle; vld from cycle 2 with instr_out 0x1000, 0x1001, ...; PC_en=1 every cycle; ocount=1.
- Backpressure: next_rdy=0 for 5 cycles after the first vld -> at most 2 issues are outstanding, code_rd_en=0 while full, instr_out held at 0x1000 with ocount rising 1..6. On release, the sequence resumes with no loss or duplication.
- branch_mispredict with target 0x20 while 1 read is in flight and the FIFO holds 1 entry -> next cycle vld=0 and code_addr=0x20; the stale data never appears; the next valid instr_pc is 0x20.
- halt and branch_mispredict in the same cycle -> IDLE, busy=0, no further code_rd_en, vld=0.
- PC wrap: CODE_ADDR_WIDTH=4, run 18 fetches -> instr_pc goes 15 then 0; ocount saturates at 63 after holding next_rdy=0 for 70 cycles.
- rst asserted in FETCH with a read in flight -> all outputs return to reset values the next cycle; a following start fetches from PC 0.
